// File: rtl/lsu_mem_if.sv
// MEM-stage load/store unit: the initiator side of a req/gnt + rvalid data-memory port.
// Places stores on byte lanes, extends loads, flags bad accesses and times out a silent memory.
module lsu_mem_if #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] result_EX_MEM,
    input  logic [31:0] Write_Data_EX_MEM,
    input  logic        Mem_Write_EX_MEM,
    input  logic        Mem_Read_EX_MEM,
    input  logic [2:0]  funct3_EX_MEM,
    output logic [31:0] Read_Data,
    output logic        stall,
    output logic        misaligned,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic          access;
    logic          illegal;
    logic          timeout;
    logic [1:0]    off;
    logic [31:0]   rdata_shift;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   load_ext;

    assign access     = Mem_Read_EX_MEM | Mem_Write_EX_MEM;
    assign off        = result_EX_MEM[1:0];
    assign misaligned = access & illegal;
    assign stall      = access & ~misaligned & (state != DONE);
    assign mem_req    = (state == REQ);
    assign mem_we     = Mem_Write_EX_MEM;
    assign mem_addr   = {result_EX_MEM[31:2], 2'b00};

    // Stores have no unsigned variants, so any funct3 with bit 2 set is illegal for a write.
    always_comb begin
        illegal = 1'b0;
        case (funct3_EX_MEM)
            3'b001, 3'b101:         illegal = off[0];
            3'b010:                 illegal = (off != 2'b00);
            3'b011, 3'b110, 3'b111: illegal = 1'b1;
            default:                illegal = 1'b0;
        endcase
        if (Mem_Write_EX_MEM && funct3_EX_MEM[2]) begin
            illegal = 1'b1;
        end
    end

    always_comb begin
        mem_be    = 4'b1111;
        mem_wdata = Write_Data_EX_MEM;
        case (funct3_EX_MEM[1:0])
            2'b00: begin
                mem_be    = 4'b0001 << off;
                mem_wdata = {4{Write_Data_EX_MEM[7:0]}};
            end
            2'b01: begin
                mem_be    = off[1] ? 4'b1100 : 4'b0011;
                mem_wdata = {2{Write_Data_EX_MEM[15:0]}};
            end
            default: begin
            end
        endcase
    end

    assign rdata_shift = mem_rdata >> {off, 3'b000};
    assign ld_byte     = rdata_shift[7:0];
    assign ld_half     = off[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        load_ext = mem_rdata;
        case (funct3_EX_MEM)
            3'b000:  load_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  load_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  load_ext = {24'd0, ld_byte};
            3'b101:  load_ext = {16'd0, ld_half};
            default: load_ext = mem_rdata;
        endcase
    end

    // A grant or rvalid in the final watchdog cycle takes priority over the timeout.
    always_comb begin
        state_nxt = state;
        timeout   = 1'b0;
        case (state)
            IDLE: begin
                if (access && !illegal) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    state_nxt = Mem_Write_EX_MEM ? DONE : WAIT_R;
                end else if (cnt == CNT_LAST) begin
                    timeout   = 1'b1;
                    state_nxt = DONE;
                end
            end
            WAIT_R: begin
                if (mem_rvalid) begin
                    state_nxt = DONE;
                end else if (cnt == CNT_LAST) begin
                    timeout   = 1'b1;
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bus_err   <= 1'b0;
            Read_Data <= '0;
        end else begin
            state   <= state_nxt;
            bus_err <= timeout;
            if (state == REQ || state == WAIT_R) begin
                cnt <= cnt + CW'(1);
            end else begin
                cnt <= '0;
            end
            if (state == WAIT_R && mem_rvalid) begin
                Read_Data <= load_ext;
            end else if (timeout && Mem_Read_EX_MEM) begin
                Read_Data <= '0;
            end
        end
    end

endmodule

// File: doc/lsu_mem_if.md
# lsu_mem_if

Load/store unit for the MEM stage: the initiator side of the data-memory interface. Takes the EX/MEM access (address, store data, read/write strobes, funct3), issues one word-aligned request with byte enables to a variable-latency data memory over a req/gnt + rvalid handshake, stalls the pipeline until the access completes, and returns the sign- or zero-extended load value. Misaligned and illegal accesses are flagged without touching memory, and a watchdog reports unresponsive memory.

## Interface
- TIMEOUT, 64: cycles allowed in REQ plus WAIT_R before bus_err; minimum 2.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- result_EX_MEM  in  32  byte address.
- Write_Data_EX_MEM  in  32  store data, right-aligned.
- Mem_Write_EX_MEM  in  1  store request.
- Mem_Read_EX_MEM  in  1  load request; never high together with Mem_Write_EX_MEM.
- funct3_EX_MEM  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- Read_Data  out  32  extended load result, registered.
- stall  out  1  freezes IF..EX/MEM while high.
- misaligned  out  1  combinational access fault.
- bus_err  out  1  one-cycle pulse on timeout.
- mem_req  out  1  request valid.
- mem_we  out  1  1 = write.
- mem_addr  out  32  {addr[31:2], 2'b00}.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  read data word.

## Operation
- access = Mem_Read_EX_MEM | Mem_Write_EX_MEM. EX/MEM inputs are held stable by the pipeline while stall=1.
- FSM states:
  - IDLE: if access and no fault, go to REQ.
  - REQ: mem_req=1; on mem_gnt, a write goes to DONE and a read goes to WAIT_R.
  - WAIT_R: on mem_rvalid, capture the extended data into Read_Data and go to DONE.
  - DONE: one cycle; the pipeline advances at its closing edge; go to IDLE.
- stall = access & ~misaligned & (state != DONE). Combinational.
- misaligned = access & (H/HU with addr[0]=1, or W with addr[1:0]!=0, or funct3 in {011, 110, 111}, or a store with funct3 of BU/HU).
- A misaligned access never leaves IDLE: no mem_req, stall=0, Read_Data unchanged.
- Byte enables:
  - B: mem_be = 1 << addr[1:0].
  - H: mem_be = addr[1] ? 1100 : 0011.
  - W: mem_be = 1111.
  - Reads drive the same enables as writes.
- mem_wdata: B replicates [7:0] into four lanes; H replicates [15:0] into two lanes; W passes through unchanged.
- Load extraction selects the lane given by addr[1:0] (B) or addr[1] (H). B/H sign-extend; BU/HU zero-extend.
- mem_addr, mem_we, mem_be and mem_wdata are valid whenever mem_req=1 and stay constant until gnt.
- Watchdog:
  - A counter clears on entering REQ and increments each cycle in REQ or WAIT_R.
  - When it reaches TIMEOUT-1 without completion: bus_err=1 for one cycle, Read_Data=0 for a read, state goes to DONE.
  - A gnt or rvalid arriving in the same cycle as the timeout wins; no bus_err is raised.
- mem_rvalid outside WAIT_R is ignored. Only one transaction is outstanding at a time.

## Timing
- Reset values: state=IDLE, Read_Data=0, counter=0, bus_err=0, mem_req=0. stall and misaligned follow their combinational equations.
- Reset mid-transaction drops mem_req immediately and abandons the access. Memory must tolerate an ungranted request being withdrawn.
- mem_rvalid is at least one cycle after mem_gnt.
- Store with gnt in its first REQ cycle: IDLE, REQ, DONE. That is 2 stall cycles; the instruction leaves MEM on the 3rd edge.
- Load with gnt immediate and rvalid one cycle later: IDLE, REQ, WAIT_R, DONE. That is 3 stall cycles; Read_Data is valid during DONE and held until the next capture.
- Each extra cycle without gnt or rvalid adds one stall cycle.
- Back-to-back accesses: DONE goes to IDLE, and the next instruction's access is evaluated in IDLE. No access is skipped or repeated.

## Test plan
- SW addr 0x100, data 0xDEADBEEF, gnt immediate -> mem_req for 1 cycle, mem_addr 0x100, mem_be 1111, mem_wdata 0xDEADBEEF, stall high exactly 2 cycles.
- SH addr 0x102, data 0x00001234, gnt after 3 cycles -> mem_be 1100, mem_wdata 0x12341234, request held stable for 4 cycles, stall high 5 cycles.
- LB and LBU at addr 0x103, mem_rdata 0x80112233 -> Read_Data 0xFFFFFF80 (LB) and 0x00000080 (LBU). LH at 0x102 with the same data -> 0xFFFF8011.
- LW addr 0x102 -> misaligned=1, stall=0, no mem_req. funct3 011 -> misaligned=1.
- LW with gnt but rvalid never, TIMEOUT=8 -> bus_err pulse 8 cycles after entering REQ, Read_Data 0, stall drops in the DONE cycle.
- Assert rst_n low while in WAIT_R -> mem_req 0, state IDLE, Read_Data 0. A late rvalid after reset release is ignored.
